fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_pkg.sv | 6 +
 rtl/fifo_rd_stream_buf.sv | 43 ++++
 rtl/fifo_rd_stream.sv | 46 ++++
 tb/tb_fifo_rd_stream.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared constants and occupancy encoding for fifo_rd_stream
package fifo_rd_stream_pkg;
    localparam int BUF_DEPTH = 2;
    localparam int COUNT_W   = 32;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;
endpackage

// File: rtl/fifo_rd_stream_buf.sv
// fifo_rd_stream_buf: 2-entry ordered register buffer, head entry always the oldest beat
module fifo_rd_stream_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DW = 104
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output occ_t          occ,
    output logic [DW-1:0] head
);
    occ_t          occ_nxt;
    logic [DW-1:0] e0, e1;
    assign head = e0;
    // occupancy register; clear dominates push/pop
    always_ff @(posedge clk)
        occ <= (!nreset || clr) ? EMPTY : occ_nxt;
    // push and pop together leave the count unchanged
    always_comb begin
        occ_nxt = occ;
        if (push && !pop)
            occ_nxt = (occ == EMPTY) ? ONE : TWO;
        else if (!push && pop)
            occ_nxt = (occ == TWO) ? ONE : EMPTY;
    end
    // on pop the second entry moves up; a new beat always lands behind the remaining one
    always_ff @(posedge clk) begin
        if (pop) begin
            e0 <= (occ == TWO) ? e1 : push_data;
            if (push && occ == TWO)
                e1 <= push_data;
        end else if (push) begin
            if (occ == EMPTY)
                e0 <= push_data;
            else
                e1 <= push_data;
        end
    end
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: next-cycle-read FIFO to valid/ready stream; out_count with FIFO_RD_STREAM_COUNT_EN
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DW = 104
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    input  logic [DW-1:0]      fifo_dout,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data
`ifdef FIFO_RD_STREAM_COUNT_EN
    ,
    output logic [COUNT_W-1:0] out_count
`endif
);
    occ_t       occ;
    logic       inflight, pop;
    logic [1:0] fill;
    assign out_valid  = nreset && occ != EMPTY;
    assign pop        = out_valid && out_ready;
    assign fill       = 2'(occ) + {1'b0, inflight} - {1'b0, pop};
    assign fifo_rd_en = !fifo_empty && !flush && nreset && fill <= 2'd1;
    // a read issued this cycle returns data on the next edge
    always_ff @(posedge clk)
        inflight <= fifo_rd_en;
    fifo_rd_stream_buf #(.DW(DW)) u_buf (
        .clk       (clk),
        .nreset    (nreset),
        .clr       (flush),
        .push      (inflight && !flush),
        .push_data (fifo_dout),
        .pop       (pop),
        .occ       (occ),
        .head      (out_data)
    );
`ifdef FIFO_RD_STREAM_COUNT_EN
    // accepted-beat counter, untouched by flush
    always_ff @(posedge clk)
        out_count <= !nreset ? '0 : out_count + COUNT_W'(pop);
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;
    localparam int DW = 104;
    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic          fifo_empty, fifo_rd_en, out_valid;
    logic [DW-1:0] fifo_dout = '0;
    logic [DW-1:0] out_data;
`ifdef FIFO_RD_STREAM_COUNT_EN
    logic [31:0]   out_count;
`endif
    logic [DW-1:0] mem [1024];
    int            wr_ptr = 0, rd_ptr = 0;
    int            rd_cnt = 0, pop_cnt = 0;
    int            checks = 0, fails = 0;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DW(DW)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef FIFO_RD_STREAM_COUNT_EN
        ,
        .out_count  (out_count)
`endif
    );

    assign fifo_empty = (rd_ptr == wr_ptr);

    // upstream sync FIFO: data appears the cycle after an accepted read
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
            rd_cnt    <= rd_cnt + 1;
        end
        if (out_valid && out_ready)
            pop_cnt <= pop_cnt + 1;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [DW-1:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            mem[wr_ptr] = first + DW'(k);
            wr_ptr++;
        end
    endtask

    task automatic drain(input logic [DW-1:0] first, input int n, input bit tog, input bit bound);
        int got = 0;
        int c = 0;
        int base = rd_cnt - pop_cnt;
        while (got < n && c < 400) begin
            @(negedge clk);
            out_ready = tog ? ~c[0] : 1'b1;
            #1;
            if (bound)
                chk("occ_bound", DW'(rd_cnt - pop_cnt - base <= 2), 1);
            if (out_valid && out_ready) begin
                chk("beat", out_data, first + DW'(got));
                got++;
            end
            c++;
        end
        chk("drain_count", DW'(got), DW'(n));
        @(negedge clk);
        #1;
        chk("drained_empty", out_valid, 0);
    endtask

    initial begin
        int rd0;
        // reset with data waiting: nothing may be read or offered
        load(1, 8);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_valid", out_valid, 0);
        // streaming 1..8 at full rate, two-cycle latency
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 0) begin
                nreset = 1'b1;
                out_ready = 1'b1;
            end
            #1;
            chk("t1_rd_en", fifo_rd_en, DW'(i < 8));
            chk("t1_valid", out_valid, DW'(i >= 2 && i < 10));
            if (i >= 2 && i < 10)
                chk("t1_data", out_data, DW'(i - 1));
        end
        // stall: only two reads issued, head held stable
        rd0 = rd_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                load('hA, 4);
                out_ready = 1'b0;
            end
            #1;
            chk("t2_rd_en", fifo_rd_en, DW'(i < 2));
            if (i >= 2) begin
                chk("t2_valid", out_valid, 1);
                chk("t2_hold", out_data, 'hA);
            end
        end
        chk("t2_reads", DW'(rd_cnt - rd0), 2);
        drain('hA, 4, 0, 0);
        // toggling ready with 16 beats queued
        load('h100, 16);
        drain('h100, 16, 1, 1);
        // flush with one buffered beat and one read in flight
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                load('h20, 8);
                out_ready = 1'b0;
            end
            flush = (i == 2);
            #1;
            if (i < 2) chk("t4_rd_en", fifo_rd_en, 1);
            if (i == 2) begin
                chk("t4_flush_rd_en", fifo_rd_en, 0);
                chk("t4_pre_flush", out_data, 'h20);
            end
            if (i == 3) chk("t4_post_flush", out_valid, 0);
        end
        drain('h22, 6, 0, 0);
        // reset mid-stream, restart from the FIFO head
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                load('h30, 8);
                out_ready = 1'b1;
            end
            nreset = !(i == 3 || i == 4);
            #1;
            if (i == 2) chk("t5_first", out_data, 'h30);
            if (i == 3 || i == 4) begin
                chk("t5_rst_valid", out_valid, 0);
                chk("t5_rst_rd_en", fifo_rd_en, 0);
            end
            if (i == 5) begin
                chk("t5_restart_rd_en", fifo_rd_en, 1);
`ifdef FIFO_RD_STREAM_COUNT_EN
                chk("t5_count_rst", out_count, 0);
`endif
            end
        end
        drain('h33, 5, 0, 0);
        // long run with a flush while the buffer is full
        load('h1000, 145);
        drain('h1000, 145, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                load('h2000, 10);
                out_ready = 1'b0;
            end
            flush = (i == 3);
            #1;
            if (i == 3) chk("t6_full_head", out_data, 'h2000);
            if (i == 4) chk("t6_post_flush", out_valid, 0);
        end
        drain('h2002, 8, 0, 0);
        load('h3000, 142);
        drain('h3000, 142, 0, 0);
`ifdef FIFO_RD_STREAM_COUNT_EN
        chk("t6_count", out_count, 300);
`endif
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
